// File: rtl/lsu_gpio_pkg.sv
// Shared constants and types for the LSU AXI GPIO / logic-analyzer slave.
package lsu_gpio_pkg;

    localparam logic [8:0] WORD_GPIO = 9'd0;
    localparam logic [8:0] WORD_LA   = 9'd1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic word_mapped(input logic [8:0] word);
        return (word == WORD_GPIO) || (word == WORD_LA);
    endfunction

    function automatic logic [63:0] strobe_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = 64'd0;
        for (int k = 0; k < 8; k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/lsu_axi_gpio_slave_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
module gpio_in_sync #(
    parameter int WIDTH = 28
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // metastability filter stages
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lsu_axi_gpio_slave.sv
// AXI4 slave mapping LSU loads/stores onto GPIO and logic-analyzer registers.
// Bursts are drained and answered with SLVERR; only single-beat accesses act.
module lsu_axi_gpio_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic [ID_W-1:0]   bid,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    input  logic [27:0]       gpio_in_i,
    output logic [27:0]       gpio_out_o,
    output logic [27:0]       gpio_oeb_o,
    output logic [31:0]       la_out_o
);
    import lsu_gpio_pkg::*;

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;

    logic [ID_W-1:0] r_bid, r_rid;
    logic [8:0]      r_wword;
    logic            r_wburst;
    logic [1:0]      r_bresp, r_rresp;
    logic [63:0]     r_rdata;
    logic            r_rlast;
    logic [8:0]      r_rbeats;
    logic [27:0]     r_gpio_out, r_gpio_oe;
    logic [31:0]     r_la;

    logic [27:0] w_gpio_in, w_gpio_out_new, w_gpio_oe_new;
    logic [31:0] w_la_new;
    logic [63:0] w_wmask, w_rword;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wapply;
    logic        w_unused;

    gpio_in_sync #(.WIDTH(28)) u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (gpio_in_i),
        .o_q   (w_gpio_in)
    );

    // Address ready is masked while reset is held so nothing is accepted then.
    assign awready = (r_wstate == W_IDLE) && !wb_rst_i;
    assign wready  = (r_wstate == W_DATA);
    assign bvalid  = (r_wstate == W_RESP);
    assign arready = (r_rstate == R_IDLE) && !wb_rst_i;
    assign rvalid  = (r_rstate == R_DATA);

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    assign w_r_hs   = rvalid && rready;
    assign w_wapply = w_w_hs && !r_wburst && word_mapped(r_wword);

    assign w_wmask        = strobe_mask(wstrb);
    assign w_gpio_out_new = (r_gpio_out & ~w_wmask[27:0])  | (wdata[27:0]  & w_wmask[27:0]);
    assign w_gpio_oe_new  = (r_gpio_oe  & ~w_wmask[59:32]) | (wdata[59:32] & w_wmask[59:32]);
    assign w_la_new       = (r_la       & ~w_wmask[31:0])  | (wdata[31:0]  & w_wmask[31:0]);

    assign w_unused = ^{awaddr[ADDR_W-1:12], awaddr[2:0], awsize,
                        araddr[ADDR_W-1:12], araddr[2:0], wdata[63:60], w_wmask[63:60]};

    // state registers for both channel FSMs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // write FSM next state
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (awvalid)          w_wstate_nxt = W_DATA; else w_wstate_nxt = W_IDLE;
            W_DATA:  if (wvalid && wlast)  w_wstate_nxt = W_RESP; else w_wstate_nxt = W_DATA;
            W_RESP:  if (bready)           w_wstate_nxt = W_IDLE; else w_wstate_nxt = W_RESP;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // read FSM next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (arvalid)           w_rstate_nxt = R_DATA; else w_rstate_nxt = R_IDLE;
            R_DATA:  if (rready && r_rlast) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_DATA;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // write address capture and response code
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_bid    <= {ID_W{1'b0}};
            r_wword  <= 9'd0;
            r_wburst <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_bid    <= awid;
                r_wword  <= awaddr[11:3];
                r_wburst <= (awlen != 8'd0);
            end
            if (w_w_hs && wlast) begin
                r_bresp <= r_wburst ? RESP_SLVERR :
                           (word_mapped(r_wword) ? RESP_OKAY : RESP_DECERR);
            end
        end
    end

    // register file updates
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_gpio_out <= 28'd0;
            r_gpio_oe  <= 28'd0;
            r_la       <= 32'd0;
        end else if (w_wapply) begin
            if (r_wword == WORD_GPIO) begin
                r_gpio_out <= w_gpio_out_new;
                r_gpio_oe  <= w_gpio_oe_new;
            end else begin
                r_la <= w_la_new;
            end
        end
    end

    // read word selection
    always_comb begin
        w_rword = 64'd0;
        case (araddr[11:3])
            WORD_GPIO: w_rword = {4'd0, r_gpio_oe, 4'd0, r_gpio_out};
            WORD_LA:   w_rword = {4'd0, w_gpio_in, r_la};
            default:   w_rword = 64'd0;
        endcase
    end

    // read capture at AR handshake and beat countdown
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rid    <= {ID_W{1'b0}};
            r_rresp  <= RESP_OKAY;
            r_rdata  <= 64'd0;
            r_rlast  <= 1'b0;
            r_rbeats <= 9'd0;
        end else if (w_ar_hs) begin
            r_rid    <= arid;
            r_rbeats <= {1'b0, arlen} + 9'd1;
            r_rlast  <= (arlen == 8'd0);
            if (arlen != 8'd0) begin
                r_rresp <= RESP_SLVERR;
                r_rdata <= 64'd0;
            end else if (!word_mapped(araddr[11:3])) begin
                r_rresp <= RESP_DECERR;
                r_rdata <= 64'd0;
            end else begin
                r_rresp <= RESP_OKAY;
                r_rdata <= w_rword;
            end
        end else if (w_r_hs) begin
            r_rbeats <= r_rbeats - 9'd1;
            r_rlast  <= (r_rbeats == 9'd2);
        end
    end

    assign bid        = r_bid;
    assign bresp      = r_bresp;
    assign rid        = r_rid;
    assign rresp      = r_rresp;
    assign rdata      = r_rdata;
    assign rlast      = r_rlast;
    assign gpio_out_o = r_gpio_out;
    assign gpio_oeb_o = ~r_gpio_oe;
    assign la_out_o   = r_la;

endmodule

// File: tb/tb_lsu_axi_gpio_slave.sv
// Scoreboard bench: tasks push expected B/R responses, a monitor pops and compares.
module tb_lsu_axi_gpio_slave;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen, wstrb;
    logic [2:0] awsize;
    logic [63:0] wdata, rdata;
    logic [1:0] bresp, rresp;
    logic [27:0] gpio_in_i, gpio_out_o, gpio_oeb_o;
    logic [31:0] la_out_o;

    lsu_axi_gpio_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .gpio_in_i(gpio_in_i), .gpio_out_o(gpio_out_o), .gpio_oeb_o(gpio_oeb_o), .la_out_o(la_out_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; logic [63:0] data; logic last; } rexp_t;
    bexp_t b_q[$];
    rexp_t r_q[$];
    bexp_t mon_b;
    rexp_t mon_r;

    int n_vec = 0;
    int n_err = 0;
    int w_stalls = 0;

    // Reference model: register contents as the software view sees them
    logic [27:0] m_out = 28'd0, m_oe = 28'd0, m_gin = 28'd0;
    logic [31:0] m_la = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake did not occur within 50 cycles", name);
    endtask

    function automatic logic [63:0] model_word(input logic [8:0] w);
        if (w == 9'd0) return {4'h0, m_oe, 4'h0, m_out};
        if (w == 9'd1) return {4'h0, m_gin, m_la};
        return 64'd0;
    endfunction

    function automatic void model_write(input logic [8:0] w, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] cur;
        cur = model_word(w);
        for (int k = 0; k < 8; k++)
            if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
        if (w == 9'd0) begin
            m_out = cur[27:0];
            m_oe  = cur[59:32];
        end else if (w == 9'd1) begin
            m_la = cur[31:0];
        end
    endfunction

    task automatic check_pins();
        logic [27:0] exp_oeb;
        exp_oeb = ~m_oe;
        chk("gpio_out_o", gpio_out_o, m_out);
        chk("gpio_oeb_o", gpio_oeb_o, exp_oeb);
        chk("la_out_o", la_out_o, m_la);
    endtask

    // Monitor: samples between the input-drive edge and the next active edge
    always @(negedge wb_clk_i) begin
        #2;
        if (wb_rst_i === 1'b0 && bvalid === 1'b1 && bready === 1'b1) begin
            if (b_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_unexpected: got bid=0x%0h bresp=%0d, expected no response", bid, bresp);
            end else begin
                mon_b = b_q.pop_front();
                chk("bid", bid, mon_b.id);
                chk("bresp", bresp, mon_b.resp);
            end
        end
        if (wb_rst_i === 1'b0 && rvalid === 1'b1 && rready === 1'b1) begin
            if (r_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL r_unexpected: got rid=0x%0h rresp=%0d, expected no beat", rid, rresp);
            end else begin
                mon_r = r_q.pop_front();
                chk("rid", rid, mon_r.id);
                chk("rresp", rresp, mon_r.resp);
                chk("rdata", rdata, mon_r.data);
                chk("rlast", rlast, mon_r.last);
            end
        end
    end

    // All tasks start and finish at a falling edge.
    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        int t;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd3;
        t = 0;
        while (!awready && t < 50) begin @(negedge wb_clk_i); t++; end
        if (t == 50) timeout_fail("aw_timeout");
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1'b1);
    endtask

    task automatic send_w(input logic [7:0] len, input logic [63:0] data, input logic [7:0] strb);
        int t;
        for (int beat = 0; beat <= int'(len); beat++) begin
            wvalid = 1'b1;
            wdata  = (beat == 0) ? data : {$urandom, $urandom};
            wstrb  = strb;
            wlast  = (beat == int'(len));
            t = 0;
            while (!wready && t < 50) begin @(negedge wb_clk_i); t++; w_stalls++; end
            if (t == 50) timeout_fail("w_timeout");
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_wlast", bvalid, 1'b1);
    endtask

    task automatic wait_b(input int delay);
        int t;
        repeat (delay) @(negedge wb_clk_i);
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge wb_clk_i); t++; end
        if (t == 50) timeout_fail("b_timeout");
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] data, input logic [7:0] strb);
        bexp_t e;
        logic [8:0] w;
        w = addr[11:3];
        e.id = id;
        if (len != 8'd0)      e.resp = SLVERR;
        else if (w > 9'd1)    e.resp = DECERR;
        else begin            e.resp = OKAY; model_write(w, data, strb); end
        b_q.push_back(e);
        send_aw(id, addr, len);
        send_w(len, data, strb);
        wait_b($urandom_range(0, 3));
        check_pins();
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        rexp_t e;
        int t;
        logic [8:0] w;
        w = addr[11:3];
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            e.last = (i == int'(len));
            if (len != 8'd0)   begin e.resp = SLVERR; e.data = 64'd0; end
            else if (w > 9'd1) begin e.resp = DECERR; e.data = 64'd0; end
            else               begin e.resp = OKAY;   e.data = model_word(w); end
            r_q.push_back(e);
        end
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
        t = 0;
        while (!arready && t < 50) begin @(negedge wb_clk_i); t++; end
        if (t == 50) timeout_fail("ar_timeout");
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        arvalid = 1'b0;
        chk("rvalid_after_ar", rvalid, 1'b1);
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
            rready = 1'b1;
            t = 0;
            while (!rvalid && t < 50) begin @(negedge wb_clk_i); t++; end
            if (t == 50) timeout_fail("r_timeout");
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            rready = 1'b0;
        end
        chk("rvalid_drop", rvalid, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      hold_resp;
        logic [ID_W-1:0] hold_id;
        logic [63:0]     d;
        logic [31:0]     a;
        logic [8:0]      w;
        logic [7:0]      l;
        bexp_t           be;

        wb_rst_i = 1'b1;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
        gpio_in_i = 28'd0;

        @(negedge wb_clk_i);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_resp", {bresp, rresp}, 4'd0);
        chk("rst_ids", {bid, rid}, 8'd0);
        chk("rst_rdata", rdata, 64'd0);
        check_pins();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        @(negedge wb_clk_i);

        do_write(4'h3, 32'h0, 8'd0, 64'h0FFF_FFFF_0000_00A5, 8'hFF);
        chk("tp_gpio_out", gpio_out_o, 28'h00000A5);
        chk("tp_gpio_oeb", gpio_oeb_o, 28'h0000000);
        do_write(4'h5, 32'h8, 8'd0, 64'h0000_0000_0000_1234, 8'h03);
        chk("tp_la", la_out_o, 32'h0000_1234);

        gpio_in_i = 28'hABCDEF1; m_gin = 28'hABCDEF1;
        repeat (3) @(negedge wb_clk_i);
        do_read(4'h6, 32'h8, 8'd0);

        do_write(4'h7, 32'h10, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_read(4'h8, 32'h10, 8'd0);

        w_stalls = 0;
        do_write(4'h9, 32'h0, 8'd3, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        chk("burst_wready_stalls", w_stalls, 0);
        do_read(4'hA, 32'h0, 8'd1);

        // B held off for five cycles: payload must not move
        d = {$urandom, $urandom};
        be.id = 4'hB; be.resp = OKAY;
        b_q.push_back(be);
        model_write(9'd0, d, 8'h5A);
        send_aw(4'hB, 32'h0, 8'd0);
        send_w(8'd0, d, 8'h5A);
        hold_resp = bresp; hold_id = bid;
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid", bvalid, 1'b1);
            chk("hold_bresp", bresp, hold_resp);
            chk("hold_bid", bid, hold_id);
            chk("hold_awready", awready, 1'b0);
            @(negedge wb_clk_i);
        end
        wait_b(0);
        check_pins();

        // Reset while the B response is pending: it must be dropped
        send_aw(4'hC, 32'h8, 8'd0);
        send_w(8'd0, 64'h0000_0000_DEAD_BEEF, 8'hFF);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("rst_mid_bvalid", bvalid, 1'b0);
        chk("rst_mid_oeb", gpio_oeb_o, 28'hFFFFFFF);
        m_out = 28'd0; m_oe = 28'd0; m_la = 32'd0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            chk("no_b_after_rst", bvalid, 1'b0);
        end
        bready = 1'b0;
        check_pins();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                gpio_in_i = 28'($urandom); m_gin = gpio_in_i;
                repeat (3) @(negedge wb_clk_i);
            end
            w = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(2, 511)) : 9'($urandom_range(0, 1));
            a = {20'($urandom), w, 3'($urandom)};
            l = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom), a, l, {$urandom, $urandom}, 8'($urandom));
            else
                do_read(4'($urandom), a, l);
        end

        repeat (3) @(negedge wb_clk_i);
        chk("b_queue_empty", b_q.size(), 0);
        chk("r_queue_empty", r_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_axi_gpio_slave.md
# lsu_axi_gpio_slave

AXI4 slave that consumes the RISC-V core's LSU AXI master port inside the Caravel user project and turns store and load traffic into a small memory-mapped GPIO / logic-analyzer register file. It replaces the tied-off ready/valid stubs with correct AW/W/B and AR/R handshakes. Its registered outputs drive `io_out[35:8]`, `io_oeb[35:8]` and the low 32 bits of `la_data_out` one level up.

## Interface
- `ID_W`, default 4: width of the AXI ID fields.
- `ADDR_W`, default 32: width of the AXI address fields.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, **synchronous, active-high**.
- `awvalid`/`awready` in/out 1; `awid` in ID_W; `awaddr` in ADDR_W; `awlen` in 8; `awsize` in 3: write address channel.
- `wvalid`/`wready` in/out 1; `wdata` in 64; `wstrb` in 8; `wlast` in 1: write data channel.
- `bvalid` out 1; `bready` in 1; `bresp` out 2; `bid` out ID_W: write response channel.
- `arvalid`/`arready` in/out 1; `arid` in ID_W; `araddr` in ADDR_W; `arlen` in 8: read address channel.
- `rvalid` out 1; `rready` in 1; `rid` out ID_W; `rdata` out 64; `rresp` out 2; `rlast` out 1: read data channel.
- `gpio_in_i` in 28: asynchronous pad inputs.
- `gpio_out_o` out 28: pad output values.
- `gpio_oeb_o` out 28: pad output enables, active-low.
- `la_out_o` out 32: logic-analyzer output word.

## Operation
- Decode uses `addr[11:3]`, which selects a 64-bit word. Byte lane k of `wdata`/`wstrb` maps to word byte k. Upper address bits are ignored.
- Word 0 is {GPIO_OE[59:32], GPIO_OUT[27:0]}.
- Word 1 is {GPIO_IN[59:32] (read-only), LA_OUT[31:0]}.
- Unused bits read as 0. Any other word returns DECERR (2'b11).
- Writes to GPIO_IN bytes are ignored and still return OKAY.
- `gpio_oeb_o = ~GPIO_OE`.
- GPIO_IN is the output of a 2-flop synchronizer on `gpio_in_i`.
- Write FSM:
  - W_IDLE (`awready`=1): on AW handshake, latch id, addr and `awlen!=0`, then go to W_DATA.
  - W_DATA (`wready`=1): on each W handshake, apply strobed bytes only if the burst flag is clear and the address decoded. On the beat with `wlast`, go to W_RESP.
  - W_RESP (`bvalid`=1): hold until `bready`, then go to W_IDLE.
- `bresp` values:
  - SLVERR (2'b10) if `awlen!=0`; no register is modified.
  - Otherwise DECERR if unmapped.
  - Otherwise OKAY.
- Read FSM:
  - R_IDLE (`arready`=1): on AR handshake, latch id, addr and beat count (`arlen+1`), then go to R_DATA.
  - R_DATA (`rvalid`=1): on each R handshake, decrement the beat count. `rlast`=1 on the final beat; after it, go to R_IDLE.
- `rresp`/`rdata` values:
  - SLVERR with `rdata`=0 if `arlen!=0`.
  - DECERR with `rdata`=0 if unmapped.
  - Otherwise OKAY with the register word.
- Read and write FSMs are fully independent.

## Timing
- Reset, at the first rising edge with `wb_rst_i`=1:
  - `awready`=`arready`=0 during reset; both are 1 on the first cycle after reset.
  - `wready`=`bvalid`=`rvalid`=`rlast`=0.
  - `bresp`=`rresp`=0; `bid`=`rid`=0; `rdata`=0.
  - `gpio_out_o`=0, `gpio_oeb_o`=all ones, `la_out_o`=0.
  - Both FSMs return to IDLE, and synchronizer flops clear to 0.
- Reset mid-transaction abandons it; no B or R is issued afterwards.
- AW handshake on cycle N gives `wready`=1 from N+1.
- A W-last handshake on cycle M updates the register at edge M. `bvalid`=1 from M+1.
- AR handshake on cycle N gives `rvalid`=1 from N+1, with `rdata` sampled from registers at edge N.
- Simultaneous write update and read capture on the same edge: the read returns the pre-write value.
- `bvalid`/`rvalid` are not withdrawn and the payload stays stable until ready (AXI rule).
- W data is never accepted before AW.
- Pad-to-readback latency is 2 cycles of synchronizer plus read latency.
- Maximum throughput: one write every 3 cycles when `bready`=1, and one single-beat read every 2 cycles.

## Structure
- Package `lsu_gpio_pkg` holds:
  - word indices (`WORD_GPIO`=0, `WORD_LA`=1);
  - response codes (`RESP_OKAY`, `RESP_SLVERR`, `RESP_DECERR`);
  - the write FSM enum `wr_state_t` {W_IDLE, W_DATA, W_RESP};
  - the read FSM enum `rd_state_t` {R_IDLE, R_DATA}.
- One sub-module, `gpio_in_sync`: a parameterized-width 2-flop synchronizer with synchronous active-high reset.

## Test plan
- Reset, then write word 0 with `wdata`=0x0FFF_FFFF_0000_00A5 and `wstrb`=0xFF -> `bresp`=OKAY with matching `bid`; `gpio_out_o`=0x00000A5; `gpio_oeb_o`=0x0000000.
- Write word 1 with `wstrb`=0x03 and `wdata`=0x1234 -> `la_out_o`=0x00001234; a later read of word 1 returns the LA lane 0x00001234.
- Drive `gpio_in_i`=0xABCDEF1, wait 2 cycles, read word 1 -> `rdata[59:32]`=0xABCDEF1, `rresp`=OKAY, `rlast`=1.
- Write with `awaddr`=0x10 -> `bresp`=DECERR and no register change. Read with `araddr`=0x10 -> `rresp`=DECERR, `rdata`=0.
- AW with `awlen`=3, followed by 4 W beats -> `wready` stays high for all 4 beats, then a single `bresp`=SLVERR; registers unchanged. AR with `arlen`=1 -> 2 SLVERR beats, `rlast` only on the second.
- Hold `bready`=0 for 5 cycles -> `bvalid`, `bresp` and `bid` stable and `awready`=0 throughout. Assert `wb_rst_i` during W_RESP -> `bvalid`=0 the next cycle and `gpio_oeb_o`=all ones.
